// File: rtl/mmu_pkg.sv
// Shared types for the TLB miss arbiter: address/ASID widths, the captured
// miss record and the walk-sequencer state encoding.
package mmu_pkg;

  typedef logic [63:0] address_t;
  typedef logic [15:0] asid_t;

  typedef struct packed {
    address_t    adr;
    asid_t       asid;
    logic [7:0]  id;
  } tlb_miss_req_t;

  typedef enum logic [1:0] {
    TMA_IDLE,
    TMA_REQ,
    TMA_WAIT
  } tlb_miss_arb_state_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int src_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tlb_miss_arbiter_if.sv
// Walker-side bus of the TLB miss arbiter. The arbiter is the master
// (issues walk requests); the page-table walker is the slave.
interface tlb_miss_arbiter_if
  import mmu_pkg::*;
#(
  parameter int NREQ = 2
) ();

  localparam int SRC_W = src_w(NREQ);

  logic             walk_req_o;
  address_t         walk_adr_o;
  asid_t            walk_asid_o;
  logic [7:0]       walk_id_o;
  logic [SRC_W-1:0] walk_src_o;
  logic             walk_ack_i;
  logic             walk_done_i;
  logic             walk_fault_i;

  modport master (
    output walk_req_o, walk_adr_o, walk_asid_o, walk_id_o, walk_src_o,
    input  walk_ack_i, walk_done_i, walk_fault_i
  );

  modport slave (
    input  walk_req_o, walk_adr_o, walk_asid_o, walk_id_o, walk_src_o,
    output walk_ack_i, walk_done_i, walk_fault_i
  );

endinterface

// File: rtl/tlb_miss_rr_pick.sv
// Combinational round-robin picker: first valid slot at or after rr_ptr,
// wrapping around NREQ.
module tlb_miss_rr_pick
  import mmu_pkg::*;
#(
  parameter  int NREQ  = 2,
  localparam int SRC_W = src_w(NREQ)
) (
  input  logic [NREQ-1:0]  slot_v_i,
  input  logic [SRC_W-1:0] rr_ptr_i,
  output logic [SRC_W-1:0] grant_o,
  output logic             grant_v_o
);

  // Scan offsets from farthest to nearest so the nearest valid slot wins last.
  always_comb begin
    grant_o   = '0;
    grant_v_o = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(rr_ptr_i) + i) % NREQ;
      if (slot_v_i[idx]) begin
        grant_o   = SRC_W'(idx);
        grant_v_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlb_miss_arbiter.sv
// TLB miss arbiter: captures per-TLB misses into slots, grants them
// round-robin to one shared page-table walker, sequences the walk handshake
// under a watchdog and reports faults/timeouts back.
// Optional feature macro TLB_MISS_MERGE_EN: a completed walk also retires
// every other pending slot with the same page number and ASID.
module tlb_miss_arbiter
  import mmu_pkg::*;
#(
  parameter  int NREQ         = 2,
  parameter  int LOG_PAGESIZE = 13,
  parameter  int TIMEOUT      = 1023,
  localparam int SRC_W        = src_w(NREQ),
  localparam int TO_BITS      = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   miss_i,
  input  address_t          miss_adr_i  [NREQ],
  input  asid_t             miss_asid_i [NREQ],
  input  logic [7:0]        miss_id_i   [NREQ],
  output logic [NREQ-1:0]   missack_o,
  tlb_miss_arbiter_if.master wbus,
  output logic              fault_o,
  output logic [SRC_W-1:0]  fault_src_o,
  output address_t          fault_adr_o,
  output logic              timeout_o,
  output logic              busy_o
);

`ifdef TLB_MISS_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  tlb_miss_arb_state_t state_q, state_d;
  logic [NREQ-1:0]     slot_v_q, slot_v_d;
  logic [NREQ-1:0]     missack_q;
  logic [NREQ-1:0]     cap, clr;
  tlb_miss_req_t       slot_q [NREQ];
  logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]    grant_q, grant_d;
  logic [SRC_W-1:0]    pick;
  logic                pick_v;
  logic [TO_BITS-1:0]  tocnt_q, tocnt_d;
  address_t            walk_adr_q, walk_adr_d;
  asid_t               walk_asid_q, walk_asid_d;
  logic [7:0]          walk_id_q, walk_id_d;
  logic                fault_q, fault_d;
  logic [SRC_W-1:0]    fault_src_q, fault_src_d;
  address_t            fault_adr_q, fault_adr_d;
  logic                timeout_q, timeout_d;
  logic                complete;

  function automatic logic same_page(input address_t a, input address_t b);
    return a[$bits(address_t)-1:LOG_PAGESIZE] == b[$bits(address_t)-1:LOG_PAGESIZE];
  endfunction

  // A slot captures only when empty and not in its ack cycle, so a held miss
  // is never taken twice.
  assign cap = miss_i & ~slot_v_q & ~missack_q;

  tlb_miss_rr_pick #(.NREQ(NREQ)) u_pick (
    .slot_v_i  (slot_v_q),
    .rr_ptr_i  (rr_ptr_q),
    .grant_o   (pick),
    .grant_v_o (pick_v)
  );

  // Walk sequencer: grant, request handshake, wait with watchdog.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    tocnt_d     = tocnt_q;
    walk_adr_d  = walk_adr_q;
    walk_asid_d = walk_asid_q;
    walk_id_d   = walk_id_q;
    fault_d     = 1'b0;
    fault_src_d = fault_src_q;
    fault_adr_d = fault_adr_q;
    timeout_d   = 1'b0;
    complete    = 1'b0;
    case (state_q)
      TMA_IDLE: begin
        if (pick_v) begin
          grant_d     = pick;
          walk_adr_d  = slot_q[pick].adr;
          walk_asid_d = slot_q[pick].asid;
          walk_id_d   = slot_q[pick].id;
          rr_ptr_d    = (pick == SRC_W'(NREQ - 1)) ? '0 : pick + 1'b1;
          state_d     = TMA_REQ;
        end
      end
      TMA_REQ: begin
        if (wbus.walk_ack_i) begin
          if (wbus.walk_done_i) begin
            complete = 1'b1;
            state_d  = TMA_IDLE;
            if (wbus.walk_fault_i) begin
              fault_d     = 1'b1;
              fault_src_d = grant_q;
              fault_adr_d = walk_adr_q;
            end
          end else begin
            tocnt_d = '0;
            state_d = TMA_WAIT;
          end
        end
      end
      TMA_WAIT: begin
        tocnt_d = tocnt_q + 1'b1;
        if (wbus.walk_done_i) begin
          complete = 1'b1;
          state_d  = TMA_IDLE;
          if (wbus.walk_fault_i) begin
            fault_d     = 1'b1;
            fault_src_d = grant_q;
            fault_adr_d = walk_adr_q;
          end
        end else if (tocnt_q == TO_BITS'(TIMEOUT - 1)) begin
          complete    = 1'b1;
          state_d     = TMA_IDLE;
          timeout_d   = 1'b1;
          fault_d     = 1'b1;
          fault_src_d = grant_q;
          fault_adr_d = walk_adr_q;
        end
      end
      default: state_d = TMA_IDLE;
    endcase
  end

  // Slots retired by a completed walk (plus same-page/ASID twins when merging).
  always_comb begin
    clr = '0;
    if (complete) begin
      clr[grant_q] = 1'b1;
      for (int k = 0; k < NREQ; k++) begin
        if (MERGE && slot_v_q[k] && same_page(slot_q[k].adr, walk_adr_q) &&
            (slot_q[k].asid == walk_asid_q))
          clr[k] = 1'b1;
      end
    end
    slot_v_d = (slot_v_q | cap) & ~clr;
  end

  // Control and output state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= TMA_IDLE;
      slot_v_q    <= '0;
      missack_q   <= '0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      tocnt_q     <= '0;
      walk_adr_q  <= '0;
      walk_asid_q <= '0;
      walk_id_q   <= '0;
      fault_q     <= 1'b0;
      fault_src_q <= '0;
      fault_adr_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_v_q    <= slot_v_d;
      missack_q   <= cap;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      tocnt_q     <= tocnt_d;
      walk_adr_q  <= walk_adr_d;
      walk_asid_q <= walk_asid_d;
      walk_id_q   <= walk_id_d;
      fault_q     <= fault_d;
      fault_src_q <= fault_src_d;
      fault_adr_q <= fault_adr_d;
      timeout_q   <= timeout_d;
    end
  end

  // Slot payload is pure data and only meaningful while slot_v is set.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NREQ; k++) begin
      if (cap[k]) begin
        slot_q[k].adr  <= miss_adr_i[k];
        slot_q[k].asid <= miss_asid_i[k];
        slot_q[k].id   <= miss_id_i[k];
      end
    end
  end

  assign missack_o        = missack_q;
  assign wbus.walk_req_o  = (state_q == TMA_REQ);
  assign wbus.walk_adr_o  = walk_adr_q;
  assign wbus.walk_asid_o = walk_asid_q;
  assign wbus.walk_id_o   = walk_id_q;
  assign wbus.walk_src_o  = grant_q;
  assign fault_o          = fault_q;
  assign fault_src_o      = fault_src_q;
  assign fault_adr_o      = fault_adr_q;
  assign timeout_o        = timeout_q;
  assign busy_o           = (|slot_v_q) | (state_q != TMA_IDLE);

endmodule
